// File: rtl/halflife_decay_ctrl.sv
// rtl/halflife_decay_ctrl.sv - half-life decay command generator (load/down strobes for the counter stage)
// Optional build macro: HALFLIFE_ROUND_EN (round-to-nearest halving instead of floor).
module halflife_decay_ctrl #(
    parameter int N = 4,
    parameter int P = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] init_qty,
    input  logic [P-1:0] period,
    input  logic         pause,
    output logic [N-1:0] qty_out,
    output logic         load_strb,
    output logic         down_strb,
    output logic [3:0]   halvings,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t       state;
    logic [P-1:0] per_r;
    logic [P-1:0] tick;
    logic [P-1:0] per_m1;
    logic [N-1:0] qty_half;
    logic         tick_term;

`ifdef HALFLIFE_ROUND_EN
    logic [N:0]   qty_inc;

    // Round-to-nearest halving at N+1 bits; 1 is forced to 0 so a run always ends.
    always_comb begin
        qty_inc  = {1'b0, qty_out} + {{N{1'b0}}, 1'b1};
        qty_half = (qty_out == {{(N-1){1'b0}}, 1'b1}) ? '0 : qty_inc[N:1];
    end
`else
    // Floor halving: plain logical shift, cannot underflow.
    always_comb begin
        qty_half = qty_out >> 1;
    end
`endif

    // Terminal tick of the current half-life period (unsigned P-bit compare).
    always_comb begin
        per_m1    = per_r - {{(P-1){1'b0}}, 1'b1};
        tick_term = (tick == per_m1);
    end

    // Main FSM. The LOAD exit edge already counts as the first tick so the first
    // down_strb lands exactly per_r cycles after load_strb.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            qty_out   <= '0;
            per_r     <= {{(P-1){1'b0}}, 1'b1};
            tick      <= '0;
            halvings  <= '0;
            load_strb <= 1'b0;
            down_strb <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            load_strb <= 1'b0;
            down_strb <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        qty_out   <= init_qty;
                        per_r     <= (period == '0) ? {{(P-1){1'b0}}, 1'b1} : period;
                        tick      <= '0;
                        halvings  <= '0;
                        load_strb <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                S_LOAD, S_RUN: begin
                    if (state == S_LOAD && qty_out == '0) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (state == S_LOAD || !pause) begin
                        if (tick_term) begin
                            tick      <= '0;
                            qty_out   <= qty_half;
                            down_strb <= 1'b1;
                            if (halvings != 4'hF) begin
                                halvings <= halvings + 4'd1;
                            end
                            if (qty_half == '0) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= S_RUN;
                            end
                        end else begin
                            tick  <= tick + {{(P-1){1'b0}}, 1'b1};
                            state <= S_RUN;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
